// File: rtl/reaction_timer_datapath.sv
// Reaction-timer datapath: ms prescaler, reaction counter, best-time record, LFSR-driven random delay.
// Registers update one cycle after their qualifying input; one_ms/zero/new_best are combinational from state.
module reaction_timer_datapath #(
  parameter int          CLK_PER_MS  = 50000,
  parameter int          MS_W        = 14,
  parameter int          RAND_W      = 13,
  parameter int          RAND_MIN_MS = 1000,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic            ck,
  input  logic            reset,
  input  logic            enable,
  input  logic            clear_ms_enable,
  input  logic            clear_count_ms,
  input  logic            write_enable,
  input  logic            load_rand,
  output logic            one_ms,
  output logic            zero,
  output logic            new_best,
  output logic [MS_W-1:0] count_ms,
  output logic [MS_W-1:0] best_ms
);

  localparam int                PRE_W    = $clog2(CLK_PER_MS);
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(CLK_PER_MS - 1);
  localparam logic [RAND_W-1:0] RAND_MIN = RAND_W'(RAND_MIN_MS);

  logic [PRE_W-1:0]  pre;
  logic [PRE_W-1:0]  rpre;
  logic [15:0]       lfsr;
  logic              lfsr_fb;
  logic [RAND_W-1:0] rcnt;
  logic [RAND_W-1:0] rand_load;
  logic              pre_last;
  logic              rpre_last;
  logic              count_max;
  logic              rcnt_zero;

  assign pre_last  = (pre == PRE_LAST);
  assign rpre_last = (rpre == PRE_LAST);
  assign count_max = &count_ms;
  assign rcnt_zero = (rcnt == '0);
  assign lfsr_fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign rand_load = RAND_MIN + RAND_W'(lfsr[10:0]);

  assign one_ms   = pre_last && !clear_ms_enable;
  assign zero     = rcnt_zero;
  assign new_best = (count_ms < best_ms);

  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      pre <= '0;
    end else if (clear_ms_enable || pre_last) begin
      pre <= '0;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  // Saturate rather than wrap so a very slow reaction never looks like a fast one.
  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      count_ms <= '0;
    end else if (clear_count_ms) begin
      count_ms <= '0;
    end else if (enable && !count_max) begin
      count_ms <= count_ms + 1'b1;
    end
  end

  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      best_ms <= '1;
    end else if (write_enable) begin
      best_ms <= count_ms;
    end
  end

  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[14:0], lfsr_fb};
    end
  end

  // Random-delay prescaler restarts on every load so the delay is an exact multiple of a ms.
  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      rpre <= '0;
    end else if (load_rand || rpre_last) begin
      rpre <= '0;
    end else begin
      rpre <= rpre + 1'b1;
    end
  end

  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      rcnt <= RAND_MIN;
    end else if (load_rand) begin
      rcnt <= rand_load;
    end else if (rpre_last && !rcnt_zero) begin
      rcnt <= rcnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_reaction_timer_datapath.sv
// Directed bench for reaction_timer_datapath with a queue of expected values popped at each check point.
module tb_reaction_timer_datapath;
  localparam int CPM = 4;

  logic ck = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic clear_ms_enable = 1'b0;
  logic clear_count_ms = 1'b0;
  logic write_enable = 1'b0;
  logic load_rand = 1'b0;
  logic enable4 = 1'b0;
  logic clear4 = 1'b0;

  logic        one_ms, zero, new_best;
  logic [13:0] count_ms, best_ms;
  logic        one_ms4, zero4, new_best4;
  logic [3:0]  count4, best4;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  logic [15:0] m_lfsr;

  reaction_timer_datapath #(.CLK_PER_MS(CPM)) dut (
    .ck(ck), .reset(reset), .enable(enable), .clear_ms_enable(clear_ms_enable),
    .clear_count_ms(clear_count_ms), .write_enable(write_enable), .load_rand(load_rand),
    .one_ms(one_ms), .zero(zero), .new_best(new_best), .count_ms(count_ms), .best_ms(best_ms)
  );

  reaction_timer_datapath #(.CLK_PER_MS(CPM), .MS_W(4)) dut4 (
    .ck(ck), .reset(reset), .enable(enable4), .clear_ms_enable(clear_ms_enable),
    .clear_count_ms(clear4), .write_enable(write_enable), .load_rand(load_rand),
    .one_ms(one_ms4), .zero(zero4), .new_best(new_best4), .count_ms(count4), .best_ms(best4)
  );

  always #5 ck = ~ck;

  // Reference LFSR: x^16+x^14+x^13+x^11+1, reset to the seed.
  always @(posedge ck or posedge reset) begin
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed %0d, no expected value queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, e);
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge ck);
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] v2;
    int          c;
    logic        seen;

    // Reset values while reset is held
    cyc(2);
    push(0);     check("rst_count", 32'(count_ms));
    push(16383); check("rst_best", 32'(best_ms));
    push(1);     check("rst_new", 32'(new_best));
    push(0);     check("rst_zero", 32'(zero));
    push(0);     check("rst_one_ms", 32'(one_ms));
    push(15);    check("rst_best4", 32'(best4));
    push(1);     check("rst_new4", 32'(new_best4));
    reset = 1'b0;

    // Count a little, record it, then reset asynchronously mid-count
    enable = 1'b1;
    cyc(5);
    enable = 1'b0;
    push(5); check("pre_rst_count", 32'(count_ms));
    write_enable = 1'b1;
    cyc(1);
    write_enable = 1'b0;
    push(5); check("pre_rst_best", 32'(best_ms));
    enable = 1'b1;
    #2 reset = 1'b1;
    #1;
    push(0);     check("mid_rst_count", 32'(count_ms));
    push(16383); check("mid_rst_best", 32'(best_ms));
    push(1);     check("mid_rst_new", 32'(new_best));
    push(0);     check("mid_rst_zero", 32'(zero));
    push(0);     check("mid_rst_one_ms", 32'(one_ms));
    enable = 1'b0;
    cyc(1);
    reset = 1'b0;

    // Millisecond tick after releasing clear_ms_enable
    clear_ms_enable = 1'b1;
    cyc(3);
    clear_ms_enable = 1'b0;
    for (int i = 0; i < 12; i++) begin
      push(32'((i % CPM) == CPM - 1)); check("tick", 32'(one_ms));
      push(32'((i % CPM) == CPM - 1)); check("tick4", 32'(one_ms4));
      cyc(1);
    end

    // Re-assert clear at cycle 5: pulse at 3 only, none at 7
    clear_ms_enable = 1'b1;
    cyc(3);
    clear_ms_enable = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i == 5) clear_ms_enable = 1'b1;
      push(32'(i == 3)); check("tick_reclear", 32'(one_ms));
      cyc(1);
    end
    clear_ms_enable = 1'b0;

    // Counter and record
    enable = 1'b1;
    cyc(250);
    enable = 1'b0;
    push(250); check("count_250", 32'(count_ms));
    write_enable = 1'b1;
    cyc(1);
    write_enable = 1'b0;
    push(250); check("best_250", 32'(best_ms));
    push(0);   check("new_equal", 32'(new_best));
    clear_count_ms = 1'b1;
    cyc(1);
    clear_count_ms = 1'b0;
    push(0); check("clear_count", 32'(count_ms));
    enable = 1'b1;
    cyc(300);
    enable = 1'b0;
    push(300); check("count_300", 32'(count_ms));
    push(0);   check("new_slower", 32'(new_best));
    clear_count_ms = 1'b1;
    cyc(1);
    clear_count_ms = 1'b0;
    enable = 1'b1;
    cyc(120);
    enable = 1'b0;
    push(120); check("count_120", 32'(count_ms));
    push(1);   check("new_faster", 32'(new_best));
    write_enable = 1'b1;
    clear_count_ms = 1'b1;
    cyc(1);
    write_enable = 1'b0;
    clear_count_ms = 1'b0;
    push(120); check("wr_clr_best", 32'(best_ms));
    push(0);   check("wr_clr_count", 32'(count_ms));

    // Saturation and clear-over-enable priority on the narrow instance
    enable4 = 1'b1;
    cyc(20);
    push(15); check("sat4", 32'(count4));
    clear4 = 1'b1;
    cyc(1);
    clear4 = 1'b0;
    enable4 = 1'b0;
    push(0); check("clr_prio4", 32'(count4));

    // Random delay: load, let it run, reload mid-countdown, then time the full countdown
    v = 32'd1000 + 32'(m_lfsr[10:0]);
    load_rand = 1'b1;
    cyc(1);
    load_rand = 1'b0;
    push(v); check("load_val", 32'(dut.rcnt));
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      seen = seen | zero;
      cyc(1);
    end
    push(0); check("zero_early", 32'(seen));
    v2 = 32'd1000 + 32'(m_lfsr[10:0]);
    load_rand = 1'b1;
    cyc(1);
    load_rand = 1'b0;
    push(v2); check("reload_val", 32'(dut.rcnt));
    push(0);  check("reload_zero", 32'(zero));
    c = 0;
    while (!zero && c < int'(v2) * CPM + 20) begin
      cyc(1);
      c++;
    end
    push(v2 * 32'(CPM)); check("zero_delay", 32'(c));
    push(1);             check("zero4", 32'(zero4));
    cyc(3);
    push(1); check("zero_hold", 32'(zero));

    // LFSR period from reset
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 65535; i++) begin
      cyc(1);
      seen = seen | (dut.lfsr == 16'h0000);
    end
    push(0);        check("lfsr_nonzero", 32'(seen));
    push(32'hACE1); check("lfsr_period", 32'(dut.lfsr));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/reaction_timer_datapath.md
# reaction_timer_datapath

Datapath for the reflex-measurement game; sits directly downstream of the game control FSM. It consumes the FSM's timing strobes and produces its status inputs:
- `one_ms`: millisecond tick while measuring.
- `zero`: random pre-LED delay has expired.
- `new`: current reaction time beats the stored record.

It also holds the reaction-time counter and best-time record for the display stage.

## Interface
Parameters:
- `CLK_PER_MS`, default 50000: clock cycles per millisecond. Must be ≥ 2.
- `MS_W`, default 14: width of the reaction-time counter and the record.
- `RAND_W`, default 13: width of the random-delay counter. Must satisfy `RAND_MIN_MS + 2047 < 2^RAND_W`.
- `RAND_MIN_MS`, default 1000: minimum random delay in ms. Must be ≥ 1.
- `LFSR_SEED`, default 16'hACE1: LFSR reset value. Must be nonzero.

Ports:
- `ck` input 1: clock, rising edge.
- `reset` input 1: reset, asynchronous, active-high.
- `enable` input 1: increment `count_ms` this cycle.
- `clear_ms_enable` input 1: hold the measuring prescaler at 0.
- `clear_count_ms` input 1: synchronous clear of `count_ms`.
- `write_enable` input 1: store `count_ms` into `best_ms`.
- `load_rand` input 1: reload the random-delay counter.
- `one_ms` output 1: single-cycle millisecond tick from the measuring prescaler.
- `zero` output 1: random-delay counter equals 0.
- `new` output 1: `count_ms < best_ms`, unsigned.
- `count_ms` output MS_W: current reaction time in ms.
- `best_ms` output MS_W: best reaction time; all-ones means no record yet.

## Operation
- **Measuring prescaler `pre`** (counts 0..CLK_PER_MS-1):
  - If `clear_ms_enable` is high: `pre` <= 0.
  - Else `pre` <= `pre` == CLK_PER_MS-1 ? 0 : `pre`+1.
  - `one_ms` = (`pre` == CLK_PER_MS-1) && !`clear_ms_enable`. Combinational, one cycle wide.
- **`count_ms`**, priority order:
  - `clear_count_ms` → 0.
  - Else `enable` → `count_ms`+1, saturating at 2^MS_W-1 (no wrap).
  - Else hold.
- **Record:**
  - `write_enable` → `best_ms` <= `count_ms`, using the register value before any same-cycle clear or increment.
  - `new` is combinational from the registers.
- **LFSR:** 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - Shifts every cycle, free-running, regardless of other inputs.
  - Feedback = `l[15]^l[13]^l[12]^l[10]`; `l` <= {`l[14:0]`, fb}.
- **Random delay:** free-running prescaler `rpre` (same count rule as `pre`) and counter `rcnt`.
  - While `load_rand` is high:
    - `rcnt` <= RAND_MIN_MS + {`l[10:0]`}, zero-extended to RAND_W. Reloads every cycle.
    - `rpre` <= 0.
  - Else: when `rpre` == CLK_PER_MS-1 and `rcnt` != 0, `rcnt` decrements.
  - At 0, `rcnt` holds until the next load.
  - `zero` = (`rcnt` == 0). Combinational.
- The measuring and random prescalers are independent. `clear_ms_enable` never affects `rcnt`.

## Timing
- **Reset values:**
  - `pre`=0, `rpre`=0, `count_ms`=0.
  - `best_ms` = all-ones, `rcnt` = RAND_MIN_MS, LFSR = LFSR_SEED.
  - Outputs therefore reset to: `one_ms`=0, `zero`=0, `new`=1.
- **`one_ms`:** `clear_ms_enable` falls with `pre`=0 at cycle 0 → `one_ms` high in cycle CLK_PER_MS-1, then every CLK_PER_MS cycles.
- **Random delay:** value V is loaded in the last `load_rand`-high cycle. `zero` rises exactly V·CLK_PER_MS cycles after `load_rand` falls (first decrement at cycle CLK_PER_MS-1).
- **Register latency:** `count_ms`, `best_ms` and `rcnt` update one cycle after the qualifying input. `new` and `zero` follow combinationally in that same cycle.
- **Simultaneous events:**
  - `clear_count_ms` with `enable`: clear wins.
  - `load_rand` with a decrement tick: load wins.
  - `write_enable` with `clear_count_ms`: `best_ms` receives the old count and the count goes to 0.
- **Mid-operation reset:** reset asserted mid-measurement returns everything to reset values immediately (asynchronous). Normal operation resumes on the first edge after deassertion.

## Test plan
Bench uses CLK_PER_MS=4.
1. **Reset:** apply reset → `count_ms`=0, `best_ms`=16383, `new`=1, `zero`=0, `one_ms`=0. Assert reset again mid-count → same values immediately.
2. **Measuring tick:** `clear_ms_enable`=1 for 3 cycles, then 0 → `one_ms` pulses on cycles 3, 7, 11 after release. Re-assert `clear_ms_enable` at cycle 5 → no pulse at 7.
3. **Counter and record:**
   - Pulse `enable` 250 times → `count_ms`=250.
   - `write_enable` → `best_ms`=250.
   - `clear_count_ms`, 300 enables → `new`=0.
   - Clear, 120 enables → `new`=1.
   - `write_enable` and `clear_count_ms` together → `best_ms`=120, `count_ms`=0.
4. **Saturation and priority:** MS_W=4, 20 enables → `count_ms`=15. Then `enable` and `clear_count_ms` together → `count_ms`=0.
5. **Random delay:** hold `load_rand` 1 cycle at known LFSR state from reset → loaded value = 1000 + LFSR[10:0]. `zero` rises exactly value·4 cycles after `load_rand` falls. Re-asserting `load_rand` mid-countdown reloads and `zero` stays 0.
6. **LFSR period:** run 65535 cycles from reset → state returns to 16'hACE1 and never equals 0.
